// File: rtl/rc4_ksa_if.sv
// Start handshake and S-memory port bundle for the RC4 key-schedule engine.
// slave is the KSA engine's view; master is the controller plus memory side.
interface rc4_ksa_if;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;

  modport slave (
    input  en,
    input  key,
    input  rddata,
    output rdy,
    output addr,
    output wrdata,
    output wren
  );

  modport master (
    output en,
    output key,
    output rddata,
    input  rdy,
    input  addr,
    input  wrdata,
    input  wren
  );
endinterface

// File: rtl/rc4_ksa.sv
// RC4 key-scheduling engine (24-bit key) driving an external 256x8 S-memory with 1-cycle read latency.
// Define RC4_KSA_INIT_EN to add an INIT pass that writes the identity permutation before scheduling.
module rc4_ksa (
  input  logic       clk,
  input  logic       rst_n,
  rc4_ksa_if.slave   bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] READ_I  = 3'd1;
  localparam logic [2:0] CAPT_I  = 3'd2;
  localparam logic [2:0] CAPT_J  = 3'd3;
  localparam logic [2:0] WRITE_J = 3'd4;
`ifdef RC4_KSA_INIT_EN
  localparam logic [2:0] INIT    = 3'd5;
`endif

  logic [2:0]  state_q, state_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic [7:0]  si_q, si_d;
  logic [23:0] key_q, key_d;
  logic [1:0]  k_q, k_d;

  logic [7:0]  kb;
  logic [7:0]  j_sum;

  // k_q tracks i mod 3 so no divider is needed to pick the key byte
  always_comb begin
    kb = key_q[7:0];
    if (k_q == 2'd0) begin
      kb = key_q[23:16];
    end else if (k_q == 2'd1) begin
      kb = key_q[15:8];
    end
    j_sum = j_q + bus.rddata + kb;
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    si_d       = si_q;
    key_d      = key_q;
    k_d        = k_q;
    bus.rdy    = 1'b0;
    bus.wren   = 1'b0;
    bus.addr   = 8'd0;
    bus.wrdata = 8'd0;

    case (state_q)
      IDLE: begin
        bus.rdy = 1'b1;
        if (bus.en) begin
          key_d = bus.key;
          i_d   = 8'd0;
          j_d   = 8'd0;
          k_d   = 2'd0;
`ifdef RC4_KSA_INIT_EN
          state_d = INIT;
`else
          state_d = READ_I;
`endif
        end
      end

`ifdef RC4_KSA_INIT_EN
      INIT: begin
        bus.addr   = i_q;
        bus.wrdata = i_q;
        bus.wren   = 1'b1;
        if (i_q == 8'd255) begin
          i_d     = 8'd0;
          j_d     = 8'd0;
          state_d = READ_I;
        end else begin
          i_d = i_q + 8'd1;
        end
      end
`endif

      READ_I: begin
        bus.addr = i_q;
        state_d  = CAPT_I;
      end

      // S[i] arrives now; the new j is used immediately as the read address of S[j]
      CAPT_I: begin
        si_d     = bus.rddata;
        j_d      = j_sum;
        bus.addr = j_sum;
        state_d  = CAPT_J;
      end

      CAPT_J: begin
        bus.addr   = i_q;
        bus.wrdata = bus.rddata;
        bus.wren   = 1'b1;
        state_d    = WRITE_J;
      end

      // when i==j both writes carry the original S[i], so the entry is unchanged
      WRITE_J: begin
        bus.addr   = j_q;
        bus.wrdata = si_q;
        bus.wren   = 1'b1;
        if (i_q == 8'd255) begin
          state_d = IDLE;
        end else begin
          i_d     = i_q + 8'd1;
          k_d     = (k_q == 2'd2) ? 2'd0 : k_q + 2'd1;
          state_d = READ_I;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      si_q    <= 8'd0;
      key_q   <= 24'd0;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      key_q   <= key_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: tb/tb_rc4_ksa.sv
// Self-checking bench for rc4_ksa: behavioural S-memory plus a loop-based KSA golden model.
// Covers reset, directed/random keys, ignored restarts, mid-run reset and back-to-back runs.
module tb_rc4_ksa;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rc4_ksa_if bus();

  rc4_ksa dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef RC4_KSA_INIT_EN
  localparam int  RUN_CYCLES = 1280;
  localparam int  RUN_WRITES = 768;
  localparam bit  INIT_BUILD = 1'b1;
`else
  localparam int  RUN_CYCLES = 1024;
  localparam int  RUN_WRITES = 512;
  localparam bit  INIT_BUILD = 1'b0;
`endif
  localparam int  TIMEOUT = 3000;

  logic [7:0] mem  [256];
  logic [7:0] gold [256];
  int         wr_count = 0;
  logic       preload_req = 1'b0;
  int         tests = 0;
  int         fails = 0;

  // synchronous-read memory; preloading is done here so mem has one writer
  always @(posedge clk) begin
    bus.rddata <= mem[bus.addr];
    if (preload_req) begin
      for (int a = 0; a < 256; a++) mem[a] = INIT_BUILD ? 8'hAA : 8'(a);
    end else if (bus.wren) begin
      mem[bus.addr] = bus.wrdata;
      wr_count = wr_count + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic void goldIdentity();
    for (int a = 0; a < 256; a++) gold[a] = 8'(a);
  endfunction

  function automatic void ksaModel(input logic [23:0] k);
    int         jj;
    logic [7:0] t;
    logic [7:0] kbytes [3];
    kbytes[0] = k[23:16];
    kbytes[1] = k[15:8];
    kbytes[2] = k[7:0];
    jj = 0;
    for (int a = 0; a < 256; a++) begin
      jj = (jj + int'(gold[a]) + int'(kbytes[a % 3])) % 256;
      t        = gold[a];
      gold[a]  = gold[jj];
      gold[jj] = t;
    end
  endfunction

  task automatic checkMem(input string tag);
    for (int a = 0; a < 256; a++)
      checkOutput($sformatf("%s S[%0d]", tag, a), 32'(mem[a]), 32'(gold[a]));
  endtask

  task automatic loadMem();
    @(negedge clk);
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
  endtask

  task automatic applyStimulus(input logic [23:0] k, input bit hold, output int wr_base);
    @(negedge clk);
    bus.key = k;
    bus.en  = 1'b1;
    wr_base = wr_count;
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.en = 1'b0;
  endtask

  // counts busy cycles at negedges; optionally re-pulses en or asserts reset mid-run
  task automatic waitDone(input int repulse_at, input int abort_at, output int low);
    bit aborted;
    low = 0;
    aborted = 1'b0;
    while (bus.rdy === 1'b0 && low < TIMEOUT && !aborted) begin
      low++;
      if (repulse_at > 0 && low == repulse_at) begin
        bus.en  = 1'b1;
        bus.key = 24'hFFFFFF;
      end else if (repulse_at > 0 && low == repulse_at + 1) begin
        bus.en = 1'b0;
      end
      if (abort_at > 0 && low == abort_at) begin
        rst_n   = 1'b0;
        aborted = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int         low;
    int         wr_base;
    int         wr_snap;
    logic [23:0] k1;
    logic [23:0] k2;

    bus.en  = 1'b0;
    bus.key = 24'd0;
    rst_n   = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    bus.en  = 1'b1;
    bus.key = 24'h00033C;
    loadMem();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset rdy", 32'(bus.rdy), 32'd1);
    checkOutput("reset wren", 32'(bus.wren), 32'd0);
    checkOutput("reset addr", 32'(bus.addr), 32'd0);
    checkOutput("reset wrdata", 32'(bus.wrdata), 32'd0);

    // en already high at release: the first rising edge after release accepts
    rst_n   = 1'b1;
    wr_base = wr_count;
    @(posedge clk);
    @(negedge clk);
    bus.en = 1'b0;
    waitDone(0, 0, low);
    checkOutput("key00033C busy cycles", 32'(low), 32'(RUN_CYCLES));
    checkOutput("key00033C writes", 32'(wr_count - wr_base), 32'(RUN_WRITES));
    goldIdentity();
    ksaModel(24'h00033C);
    checkMem("key00033C");

    loadMem();
    applyStimulus(24'h000000, 1'b0, wr_base);
    waitDone(0, 0, low);
    checkOutput("key000000 busy cycles", 32'(low), 32'(RUN_CYCLES));
    checkOutput("key000000 writes", 32'(wr_count - wr_base), 32'(RUN_WRITES));
    goldIdentity();
    ksaModel(24'h000000);
    checkMem("key000000");

    k1 = 24'($urandom);
    loadMem();
    applyStimulus(k1, 1'b0, wr_base);
    waitDone(300, 0, low);
    checkOutput("repulse busy cycles", 32'(low), 32'(RUN_CYCLES));
    goldIdentity();
    ksaModel(k1);
    checkMem("repulse");

    k1 = 24'($urandom);
    loadMem();
    applyStimulus(k1, 1'b0, wr_base);
    waitDone(0, 500, low);
    #1;
    checkOutput("abort rdy", 32'(bus.rdy), 32'd1);
    checkOutput("abort wren", 32'(bus.wren), 32'd0);
    checkOutput("abort addr", 32'(bus.addr), 32'd0);
    wr_snap = wr_count;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("abort no writes", 32'(wr_count - wr_snap), 32'd0);
    rst_n = 1'b1;
    loadMem();
    applyStimulus(k1, 1'b0, wr_base);
    waitDone(0, 0, low);
    checkOutput("after abort busy cycles", 32'(low), 32'(RUN_CYCLES));
    goldIdentity();
    ksaModel(k1);
    checkMem("after abort");

    k1 = 24'($urandom);
    k2 = 24'($urandom);
    loadMem();
    applyStimulus(k1, 1'b1, wr_base);
    waitDone(0, 0, low);
    checkOutput("b2b first busy cycles", 32'(low), 32'(RUN_CYCLES));
    goldIdentity();
    ksaModel(k1);
    checkMem("b2b first");
    checkOutput("b2b idle rdy", 32'(bus.rdy), 32'd1);
    bus.key = k2;
    wr_base = wr_count;
    @(posedge clk);
    @(negedge clk);
    bus.en = 1'b0;
    checkOutput("b2b restarted", 32'(bus.rdy), 32'd0);
    waitDone(0, 0, low);
    checkOutput("b2b second busy cycles", 32'(low), 32'(RUN_CYCLES));
    checkOutput("b2b second writes", 32'(wr_count - wr_base), 32'(RUN_WRITES));
    // without INIT the second run permutes whatever the first run left behind
    if (INIT_BUILD) goldIdentity();
    ksaModel(k2);
    checkMem("b2b second");

    for (int n = 0; n < 2; n++) begin
      k1 = 24'($urandom);
      loadMem();
      applyStimulus(k1, 1'b0, wr_base);
      waitDone(0, 0, low);
      checkOutput($sformatf("random%0d busy cycles", n), 32'(low), 32'(RUN_CYCLES));
      goldIdentity();
      ksaModel(k1);
      checkMem($sformatf("random%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rc4_ksa.md
RC4_KSA -- requirements
Module: rc4_ksa

Interface
REQ-001 SHALL use one clock and asynchronous active-low reset, with ports clk then rst_n.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port en  input  1  start request, sampled only while rdy=1.
REQ-005 SHALL have port rdy  output  1  high = idle and able to accept en.
REQ-006 SHALL have port key  input  24  cipher key, latched on the accepting edge.
REQ-007 SHALL have port addr  output  8  S-memory address.
REQ-008 SHALL have port rddata  input  8  S-memory read data, valid one cycle after addr is presented.
REQ-009 SHALL have port wrdata  output  8  S-memory write data.
REQ-010 SHALL have port wren  output  1  S-memory write enable, one write per asserted cycle.

Function
REQ-011 SHALL perform the RC4 key schedule: j=0; for i=0..255: j=(j+S[i]+kb[i mod 3]) mod 256, then swap S[i] and S[j].
REQ-012 SHALL define kb[0]=key[23:16], kb[1]=key[15:8], kb[2]=key[7:0].
REQ-013 SHALL do all index and sum arithmetic in 8 bits, wrapping modulo 256 with no carry kept.
REQ-014 SHALL accept a start on a rising edge where rdy=1 and en=1, latching key and clearing i and j to 0.
REQ-015 SHALL drop rdy in the cycle after the accepting edge.
REQ-016 SHALL use states IDLE, READ_I, CAPT_I, CAPT_J, WRITE_J, and INIT when REQ-031 applies.
REQ-017 SHALL in READ_I: addr=i, wren=0.
REQ-018 SHALL in CAPT_I: register si=rddata, compute j_new=j+si+kb, register j=j_new, drive addr=j_new, wren=0.
REQ-019 SHALL in CAPT_J: drive addr=i, wrdata=rddata (S[j]), wren=1.
REQ-020 SHALL in WRITE_J: drive addr=j, wrdata=si, wren=1.
REQ-021 SHALL on leaving WRITE_J go to READ_I with i+1 if i<255, else go to IDLE.
REQ-022 SHALL take exactly 4 cycles per iteration and keep rdy low for exactly 1024 cycles without REQ-031.
REQ-023 SHALL for i==j write the same original value twice, leaving S[i] unchanged.
REQ-024 SHALL ignore en while rdy=0: no restart, and key is not relatched.
REQ-025 SHALL if en=1 in the first IDLE cycle after completion, start a new run at that edge (back-to-back allowed).
REQ-026 SHALL keep wren=0 in IDLE and READ_I/CAPT_I, with addr and wrdata then don't-care.

Reset
REQ-027 SHALL on rst_n=0 immediately (asynchronously) force state=IDLE, rdy=1, wren=0, addr=0, wrdata=0, i=0, j=0, si=0, latched key=0.
REQ-028 SHALL on reset mid-run abort with no further writes, leaving S contents undefined and not repaired.
REQ-029 SHALL ignore en while rst_n=0, and accept it no earlier than the first rising edge after release.

Configuration
REQ-030 SHALL use macro RC4_KSA_INIT_EN.
REQ-031 SHALL when RC4_KSA_INIT_EN is defined, enter INIT after the accepting edge and write S[i]=i for i=0..255, one per cycle with wren=1, then enter READ_I with i=0 and j=0; rdy then stays low exactly 1280 cycles.
REQ-032 SHALL when RC4_KSA_INIT_EN is undefined, omit INIT, require S to hold the identity permutation beforehand, and keep rdy low exactly 1024 cycles.

Verification
REQ-033 SHALL cover: identity S preloaded, key=24'h00033C, en pulse -> final S equals golden-model KSA output for 00033C, and rdy is low exactly 1024 cycles.
REQ-034 SHALL cover: key=24'h000000 -> final S equals golden model, and no write occurs while wren=0.
REQ-035 SHALL cover: en re-pulsed at cycle 300 with key=24'hFFFFFF -> ignored, and result still matches the original key.
REQ-036 SHALL cover: rst_n low at cycle 500 -> rdy=1 and wren=0 before the next edge, and a fresh run after release matches golden.
REQ-037 SHALL cover: en held high across completion -> second run starts in the first IDLE cycle and both results match golden.
REQ-038 SHALL cover: with RC4_KSA_INIT_EN, S preloaded with 8'hAA -> identity init, then final S matches golden, and rdy is low 1280 cycles.
